// File: rtl/rx_lane_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : rx_lane_byte_packer
// Description : Packs the valid bytes of each RX lane-controller write into a
//               circular byte buffer and emits fixed-width beats to the
//               framing/data-link stage over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_lane_byte_packer #(
    parameter int IN_BYTES    = 64,
    parameter int OUT_BYTES   = 16,
    parameter int DEPTH_BYTES = 256,
    parameter int LVL_W       = $clog2(DEPTH_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   linkup,
    input  logic                   wr_en,
    input  logic [IN_BYTES-1:0]    wr_mask,
    input  logic [8*IN_BYTES-1:0]  wr_data,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [8*OUT_BYTES-1:0] rd_data,
    output logic [LVL_W-1:0]       level,
    output logic                   overflow,
    output logic                   mask_err
);

    localparam int               C_PTR_W = $clog2(DEPTH_BYTES);
    localparam int               C_CNT_W = $clog2(IN_BYTES + 1);
    localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH_BYTES);
    localparam logic [LVL_W-1:0] C_OUT   = LVL_W'(OUT_BYTES);

    logic [7:0]         mem_q [DEPTH_BYTES];
    logic [7:0]         mem_d [DEPTH_BYTES];
    logic [C_PTR_W-1:0] wptr_q, wptr_d;
    logic [C_PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic               mask_err_q, mask_err_d;

    logic [C_CNT_W-1:0]  w_cnt;
    logic [IN_BYTES-1:0] w_therm;
    logic                w_mask_ok;
    logic                w_space_ok;
    logic                w_wr_accept;
    logic                w_fire;
    logic [LVL_W-1:0]    w_add;
    logic [LVL_W-1:0]    w_sub;

    // Byte count of the incoming write (popcount of the mask)
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            w_cnt = w_cnt + C_CNT_W'(wr_mask[i]);
        end
    end

    // Reference thermometer for the counted bytes; also selects bytes to store
    always_comb begin
        w_therm = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            w_therm[i] = (C_CNT_W'(i) < w_cnt);
        end
    end

    // Space check uses the registered level only, so freed space is never
    // counted before the read that frees it has actually happened
    assign w_mask_ok   = (wr_mask == w_therm);
    assign w_space_ok  = (LVL_W'(w_cnt) <= (C_DEPTH - level_q));
    assign w_wr_accept = wr_en & linkup & w_mask_ok & w_space_ok;
    assign rd_valid    = (level_q >= C_OUT);
    assign w_fire      = rd_valid & rd_ready;
    assign w_add       = w_wr_accept ? LVL_W'(w_cnt) : '0;
    assign w_sub       = w_fire ? C_OUT : '0;

    // Pointer, level and sticky-flag next state; a link drop flushes everything
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        mask_err_d = mask_err_q;
        if (!linkup) begin
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            mask_err_d = 1'b0;
        end else begin
            // An illegal mask is reported in preference to a lack of space
            if (wr_en && !w_mask_ok) begin
                mask_err_d = 1'b1;
            end else if (wr_en && !w_space_ok) begin
                overflow_d = 1'b1;
            end
            if (w_wr_accept) begin
                wptr_d = wptr_q + C_PTR_W'(w_cnt);
            end
            if (w_fire) begin
                rptr_d = rptr_q + C_PTR_W'(OUT_BYTES);
            end
            level_d = level_q + w_add - w_sub;
        end
    end

    // Scatter the valid bytes into the ring, wrapping seamlessly at the end
    always_comb begin
        mem_d = mem_q;
        if (w_wr_accept) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                if (w_therm[i]) begin
                    mem_d[wptr_q + C_PTR_W'(i)] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // Output beat: OUT_BYTES bytes from the read pointer, oldest in the low byte
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            rd_data[8*j +: 8] = mem_q[rptr_q + C_PTR_W'(j)];
        end
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            mask_err_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            mask_err_q <= mask_err_d;
        end
    end

    // Byte storage; contents are don't-care after reset so no clear is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign level    = level_q;
    assign overflow = overflow_q;
    assign mask_err = mask_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_lane_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_lane_byte_packer
// Description : Directed scoreboard bench for rx_lane_byte_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_lane_byte_packer;

    logic         clk;
    logic         rst_n;
    logic         linkup;
    logic         wr_en;
    logic [63:0]  wr_mask;
    logic [511:0] wr_data;
    logic         rd_ready;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic [8:0]   level;
    logic         overflow;
    logic         mask_err;

    int n_vec;
    int n_err;

    logic [7:0]   mq[$];
    logic [127:0] expq[$];

    rx_lane_byte_packer #(
        .IN_BYTES    (64),
        .OUT_BYTES   (16),
        .DEPTH_BYTES (256),
        .LVL_W       (9)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .linkup   (linkup),
        .wr_en    (wr_en),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .level    (level),
        .overflow (overflow),
        .mask_err (mask_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [511:0] mk(input logic [7:0] base, input int n);
        logic [511:0] d;
        d = {64{8'hEE}};
        for (int i = 0; i < n; i++) d[8*i +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [63:0] mk_mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    // One write cycle; accepted bytes feed the byte model, full beats the scoreboard
    task automatic wr(input logic [63:0] m, input logic [511:0] d, input int n, input bit acc);
        logic [127:0] beat;
        wr_mask = m;
        wr_data = d;
        wr_en   = 1'b1;
        if (acc) begin
            for (int i = 0; i < n; i++) mq.push_back(d[8*i +: 8]);
            while (mq.size() >= 16) begin
                for (int j = 0; j < 16; j++) beat[8*j +: 8] = mq.pop_front();
                expq.push_back(beat);
            end
        end
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_mask = '0;
    endtask

    task automatic flush_cyc(input bit we, input bit rr);
        linkup   = 1'b0;
        wr_en    = we;
        wr_mask  = '1;
        wr_data  = mk(8'h99, 64);
        rd_ready = rr;
        @(posedge clk);
        #1;
        linkup   = 1'b1;
        wr_en    = 1'b0;
        wr_mask  = '0;
        rd_ready = 1'b0;
        mq.delete();
        expq.delete();
    endtask

    // Monitor: every presented beat must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_unexpected: got %0h expected none", rd_data);
            end else begin
                chk("beat", rd_data, expq[0]);
                if (rd_ready && linkup) void'(expq.pop_front());
            end
        end
    end

    initial begin
        logic [7:0]   b;
        logic [511:0] d;
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        linkup   = 1'b1;
        wr_en    = 1'b0;
        wr_mask  = '0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_level", 128'(level), 0);
        chk("rst_valid", 128'(rd_valid), 0);
        chk("rst_ovf", 128'(overflow), 0);
        chk("rst_merr", 128'(mask_err), 0);

        // Gen1 x1 stream
        rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wr(64'h1, mk(8'(k), 1), 1, 1'b1);
            if (k == 14) begin
                chk("x1_level15", 128'(level), 15);
                chk("x1_valid15", 128'(rd_valid), 0);
            end
        end
        chk("x1_level16", 128'(level), 16);
        chk("x1_valid16", 128'(rd_valid), 1);
        chk("x1_data", rd_data, 128'h0F0E0D0C0B0A09080706050403020100);
        @(posedge clk);
        #1;
        chk("x1_drained", 128'(level), 0);

        // Full-width burst
        wr(mk_mask(64), mk(8'h00, 64), 64, 1'b1);
        chk("burst_level", 128'(level), 64);
        chk("burst_lo0", 128'(rd_data[7:0]), 0);
        for (int s = 1; s <= 4; s++) begin
            @(posedge clk);
            #1;
            chk("burst_level", 128'(level), 128'(64 - 16 * s));
            if (s < 4) chk("burst_lo", 128'(rd_data[7:0]), 128'(16 * s));
        end

        // Wrap: 87 three-byte writes with interleaved reads
        b = 8'h40;
        for (int k = 0; k < 87; k++) begin
            rd_ready = (k % 3 != 0);
            wr(64'h7, mk(b, 3), 3, 1'b1);
            b = b + 8'd3;
        end
        rd_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("wrap_residue", 128'(level), 5);
        chk("wrap_valid", 128'(rd_valid), 0);
        chk("wrap_sb_empty", 128'(expq.size()), 0);
        flush_cyc(1'b0, 1'b0);
        chk("flush1_level", 128'(level), 0);

        // Overflow
        for (int k = 0; k < 4; k++) begin
            wr(mk_mask(64), mk(8'(64 * k), 64), 64, 1'b1);
        end
        chk("ovf_level_full", 128'(level), 256);
        chk("ovf_valid_full", 128'(rd_valid), 1);
        wr(64'h5, mk(8'h77, 3), 0, 1'b0);
        chk("full_merr", 128'(mask_err), 1);
        chk("full_merr_no_ovf", 128'(overflow), 0);
        wr(64'h1, mk(8'h55, 1), 0, 1'b0);
        chk("ovf_flag", 128'(overflow), 1);
        chk("ovf_level_hold", 128'(level), 256);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        chk("ovf_after_read", 128'(level), 240);
        wr(64'h1, mk(8'hAB, 1), 1, 1'b1);
        chk("ovf_accept", 128'(level), 241);
        flush_cyc(1'b0, 1'b0);
        chk("flush2_level", 128'(level), 0);
        chk("flush2_ovf", 128'(overflow), 0);
        chk("flush2_merr", 128'(mask_err), 0);

        // Mask error
        wr(64'h5, mk(8'h10, 3), 0, 1'b0);
        chk("merr_flag", 128'(mask_err), 1);
        chk("merr_level", 128'(level), 0);
        chk("merr_ovf", 128'(overflow), 0);

        // Flush overriding write and read
        wr(mk_mask(40), mk(8'h20, 40), 40, 1'b1);
        chk("pre_flush_level", 128'(level), 40);
        flush_cyc(1'b1, 1'b1);
        chk("flush_level", 128'(level), 0);
        chk("flush_valid", 128'(rd_valid), 0);
        chk("flush_merr", 128'(mask_err), 0);
        chk("flush_ovf", 128'(overflow), 0);

        // Asynchronous reset between edges
        wr(mk_mask(20), mk(8'h60, 20), 20, 1'b1);
        wr(64'h2, mk(8'h61, 1), 0, 1'b0);
        chk("pre_rst_level", 128'(level), 20);
        chk("pre_rst_merr", 128'(mask_err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 128'(level), 0);
        chk("arst_valid", 128'(rd_valid), 0);
        chk("arst_merr", 128'(mask_err), 0);
        mq.delete();
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Operation resumes cleanly after reset
        rd_ready = 1'b1;
        wr(mk_mask(16), mk(8'h30, 16), 16, 1'b1);
        d = mk(8'h30, 16);
        chk("post_rst_data", rd_data, d[127:0]);
        @(posedge clk);
        #1;
        chk("post_rst_level", 128'(level), 0);
        chk("final_sb_empty", 128'(expq.size()), 0);
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
